// File: rtl/imem_program_loader.sv
// imem_program_loader
//   Takes compact op records (op, rs, rt, rd, imm) from a valid/ready stream.
//   Encodes each record into a 32-bit MIPS instruction word.
//   Writes the words into instruction memory at consecutive word addresses,
//   starting from 0, and holds the CPU in reset until the program is loaded.
//
// Parameters
//   DEPTH   instruction memory capacity in words (power of 2, 2..1024)
//   ADDR_W  width of imem_addr_o (byte address)
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous reset, active low
//   start_i      begin a new load (pulse); ignored while loading
//   in_valid_i   op record valid
//   in_ready_o   loader accepts a record this cycle (high only while loading)
//   in_last_i    record is the final instruction of the program
//   op_i         op selector, 16 legal values
//   rs_i/rt_i/rd_i  register fields
//   imm_i        immediate / branch offset, passed through raw
//   imem_we_o    instruction memory write strobe (one cycle per record)
//   imem_addr_o  byte address of the write (word index * 4)
//   imem_data_o  encoded instruction word
//   count_o      words written in the current load
//   cpu_run_o    program loaded, CPU may leave reset
//   err_o        DEPTH words written without a last record
//   checksum_o   XOR of all written words in the current load
//
// Optional feature
//   LOADER_CHECKSUM_EN: when defined, checksum_o accumulates each written word.
//   When undefined, checksum_o is tied to zero and no accumulator exists.

module imem_program_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_last_i,
    input  logic [3:0]        op_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [15:0]       imm_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_data_o,
    output logic [10:0]       count_o,
    output logic              cpu_run_o,
    output logic              err_o,
    output logic [31:0]       checksum_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [10:0] LAST_IDX = 11'(DEPTH - 1);

    logic [1:0]  state;
    logic        handshake;
    logic [31:0] enc_word;

    assign in_ready_o = (state == S_LOAD);
    assign handshake  = in_valid_i & in_ready_o;

    // Ops 0..7 are R-type (opcode 0, funct selects the ALU op),
    // ops 8..15 are I-type (opcode selects the op, rd is ignored).
    function automatic logic [31:0] encode(
        input logic [3:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm
    );
        logic [5:0]  funct;
        logic [5:0]  opcode;
        logic [31:0] word;
        funct  = 6'd0;
        opcode = 6'd0;
        word   = 32'h0;
        case (op)
            4'd1:  funct  = 6'd32;
            4'd2:  funct  = 6'd34;
            4'd3:  funct  = 6'd36;
            4'd4:  funct  = 6'd37;
            4'd5:  funct  = 6'd38;
            4'd6:  funct  = 6'd42;
            4'd7:  funct  = 6'd24;
            4'd8:  opcode = 6'd8;
            4'd9:  opcode = 6'd10;
            4'd10: opcode = 6'd35;
            4'd11: opcode = 6'd43;
            4'd12: opcode = 6'd4;
            4'd13: opcode = 6'd5;
            4'd14: opcode = 6'd7;
            4'd15: opcode = 6'd1;
            default: ;
        endcase
        if (op == 4'd0)
            word = 32'h0;                      // nop is the all-zero word
        else if (op[3] == 1'b0)
            word = {6'd0, rs, rt, rd, 5'd0, funct};
        else
            word = {opcode, rs, rt, imm};
        return word;
    endfunction

    assign enc_word = encode(op_i, rs_i, rt_i, rd_i, imm_i);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= S_IDLE;
            imem_we_o   <= 1'b0;
            imem_addr_o <= '0;
            imem_data_o <= 32'h0;
            count_o     <= 11'd0;
            cpu_run_o   <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            imem_we_o <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (handshake) begin
                        // Address uses the pre-increment count so the first word lands at 0.
                        imem_we_o   <= 1'b1;
                        imem_addr_o <= ADDR_W'({count_o, 2'b00});
                        imem_data_o <= enc_word;
                        count_o     <= count_o + 11'd1;
                        if (in_last_i) begin
                            state     <= S_DONE;
                            cpu_run_o <= 1'b1;
                        end else if (count_o == LAST_IDX) begin
                            state <= S_ERR;
                            err_o <= 1'b1;
                        end
                    end
                end
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_i) begin
                        state       <= S_LOAD;
                        imem_addr_o <= '0;
                        count_o     <= 11'd0;
                        cpu_run_o   <= 1'b0;
                        err_o       <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] checksum_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i)
            checksum_q <= 32'h0;
        else if (start_i && (state != S_LOAD))
            checksum_q <= 32'h0;
        else if (handshake)
            checksum_q <= checksum_q ^ enc_word;
    end

    assign checksum_o = checksum_q;
`else
    assign checksum_o = 32'h0;
`endif

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader, built with DEPTH=4 so the
// overflow and last-word boundaries are reachable with short programs.
module tb_imem_program_loader;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_last = 1'b0;
    logic [3:0]        op = 4'd0;
    logic [4:0]        rs = 5'd0, rt = 5'd0, rd = 5'd0;
    logic [15:0]       imm = 16'h0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic [10:0]       count;
    logic              cpu_run;
    logic              err;
    logic [31:0]       checksum;

    int checks = 0;
    int failures = 0;

    imem_program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_last_i(in_last),
        .op_i(op), .rs_i(rs), .rt_i(rt), .rd_i(rd), .imm_i(imm),
        .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_data_o(imem_data),
        .count_o(count), .cpu_run_o(cpu_run), .err_o(err), .checksum_o(checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Presents one record, waits (bounded) for ready, completes the handshake.
    // On return the write cycle is visible on the outputs.
    task automatic send(input logic [3:0] o, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [15:0] im, input logic lst);
        int n = 0;
        op = o; rs = s; rt = t; rd = d; imm = im; in_last = lst;
        in_valid = 1'b1;
        while (!in_ready && n < 10) begin
            tick();
            n++;
        end
        if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Hand-encoded words for rs=1 rt=2 rd=3 imm=16'h1234, indexed by op.
    logic [31:0] enc_tab [16] = '{
        32'h00000000, 32'h00221820, 32'h00221822, 32'h00221824,
        32'h00221825, 32'h00221826, 32'h0022182A, 32'h00221818,
        32'h20221234, 32'h28221234, 32'h8C221234, 32'hAC221234,
        32'h10221234, 32'h14221234, 32'h1C221234, 32'h04221234
    };

    logic [31:0] exp_ck;

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_data", imem_data, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_run", 32'(cpu_run), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_ck", checksum, 32'd0);
        rst = 1'b1;
        tick();
        chk("idle_ready", 32'(in_ready), 32'd0);

        // Test 1: single add record
        pulse_start();
        chk("t1_ready", 32'(in_ready), 32'd1);
        send(4'd1, 5'd2, 5'd3, 5'd4, 16'h0, 1'b1);
        chk("t1_we", 32'(imem_we), 32'd1);
        chk("t1_addr", imem_addr, 32'd0);
        chk("t1_data", imem_data, 32'h00432020);
        chk("t1_run", 32'(cpu_run), 32'd1);
        chk("t1_count", 32'(count), 32'd1);
        tick();
        chk("t1_we_drop", 32'(imem_we), 32'd0);
        chk("t1_run_hold", 32'(cpu_run), 32'd1);
        chk("t1_ready_done", 32'(in_ready), 32'd0);

        // Test 2: lw then beq, checksum
        pulse_start();
        chk("t2_run_clr", 32'(cpu_run), 32'd0);
        send(4'd10, 5'd0, 5'd8, 5'd0, 16'h0004, 1'b0);
        chk("t2_w0_data", imem_data, 32'h8C080004);
        chk("t2_w0_addr", imem_addr, 32'd0);
        chk("t2_w0_run", 32'(cpu_run), 32'd0);
        send(4'd12, 5'd8, 5'd9, 5'd0, 16'hFFFF, 1'b1);
        chk("t2_w1_data", imem_data, 32'h1109FFFF);
        chk("t2_w1_addr", imem_addr, 32'd4);
        chk("t2_run", 32'(cpu_run), 32'd1);
        chk("t2_count", 32'(count), 32'd2);
`ifdef LOADER_CHECKSUM_EN
        exp_ck = 32'h9D01FFFB;
`else
        exp_ck = 32'h0;
`endif
        chk("t2_ck", checksum, exp_ck);

        // Test 3: DEPTH records without last -> overflow
        pulse_start();
        for (int i = 0; i < DEPTH; i++) begin
            send(4'd8, 5'd1, 5'd2, 5'd0, 16'(i), 1'b0);
            chk($sformatf("t3_addr%0d", i), imem_addr, 32'(i * 4));
        end
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_ready", 32'(in_ready), 32'd0);
        chk("t3_run", 32'(cpu_run), 32'd0);
        chk("t3_count", 32'(count), 32'd4);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t3_no_write", 32'(imem_we), 32'd0);
        chk("t3_err_hold", 32'(err), 32'd1);

        // Test 4: last on word DEPTH-1 -> done, not error
        pulse_start();
        chk("t4_err_clr", 32'(err), 32'd0);
        for (int i = 0; i < DEPTH - 1; i++) send(4'd4, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
        send(4'd5, 5'd1, 5'd2, 5'd3, 16'h0, 1'b1);
        chk("t4_addr", imem_addr, 32'd12);
        chk("t4_run", 32'(cpu_run), 32'd1);
        chk("t4_err", 32'(err), 32'd0);

        // start_i ignored while loading
        pulse_start();
        send(4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
        pulse_start();
        send(4'd3, 5'd1, 5'd2, 5'd3, 16'h0, 1'b1);
        chk("ign_addr", imem_addr, 32'd4);
        chk("ign_count", 32'(count), 32'd2);

        // Test 5: reset mid-load
        pulse_start();
        send(4'd1, 5'd1, 5'd1, 5'd1, 16'h0, 1'b0);
        send(4'd1, 5'd2, 5'd2, 5'd2, 16'h0, 1'b0);
        rst = 1'b0;
        in_valid = 1'b1;
        tick();
        chk("t5_we", 32'(imem_we), 32'd0);
        chk("t5_addr", imem_addr, 32'd0);
        chk("t5_data", imem_data, 32'd0);
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_ck", checksum, 32'd0);
        rst = 1'b1;
        tick();
        chk("t5_idle_ready", 32'(in_ready), 32'd0);
        chk("t5_idle_we", 32'(imem_we), 32'd0);
        in_valid = 1'b0;
        pulse_start();
        send(4'd6, 5'd1, 5'd2, 5'd3, 16'h0, 1'b1);
        chk("t5_reload_addr", imem_addr, 32'd0);
        chk("t5_reload_data", imem_data, 32'h0022182A);

        // Encoding of all 16 ops
        for (int k = 0; k < 16; k++) begin
            pulse_start();
            send(4'(k), 5'd1, 5'd2, 5'd3, 16'h1234, 1'b1);
            chk($sformatf("enc_op%0d", k), imem_data, enc_tab[k]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
